// File: rtl/eth_tx_pkg.sv
// Shared constants, one-hot state encoding and nibble-serial CRC-32 step for the MII transmit framer.
package eth_tx_pkg;

   localparam int IDX_IDLE     = 0;
   localparam int IDX_PREAMBLE = 1;
   localparam int IDX_DATA0    = 2;
   localparam int IDX_DATA1    = 3;
   localparam int IDX_PAD      = 4;
   localparam int IDX_FCS      = 5;
   localparam int IDX_JAM      = 6;
   localparam int IDX_IPG      = 7;

   typedef enum logic [7:0] {
      ST_IDLE     = 8'b1 << IDX_IDLE,
      ST_PREAMBLE = 8'b1 << IDX_PREAMBLE,
      ST_DATA0    = 8'b1 << IDX_DATA0,
      ST_DATA1    = 8'b1 << IDX_DATA1,
      ST_PAD      = 8'b1 << IDX_PAD,
      ST_FCS      = 8'b1 << IDX_FCS,
      ST_JAM      = 8'b1 << IDX_JAM,
      ST_IPG      = 8'b1 << IDX_IPG
   } txState_t;

   localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
   localparam logic [3:0]  SFD_NIB      = 4'hD;
   localparam logic [3:0]  JAM_NIB      = 4'h9;
   localparam int          PREAMBLE_LEN = 16;
   localparam int          FCS_NIB      = 8;
   localparam int          JAM_NIB_CNT  = 8;
   localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

   // Bit 0 of the nibble leaves the wire first, so it is folded into the register first.
   function automatic logic [31:0] crcNibble(input logic [31:0] crc, input logic [3:0] nib);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 4; i++) begin
         if (c[31] ^ nib[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
         else                c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_txcrc.sv
// Nibble-serial Ethernet CRC-32: Initialize loads all ones, Enable folds in Data, Shift walks the FCS out.
module eth_txcrc
   import eth_tx_pkg::*;
(
   input  logic       MTxClk,
   input  logic       Reset_n,
   input  logic       Initialize,
   input  logic       Enable,
   input  logic       Shift,
   input  logic [3:0] Data,
   output logic [3:0] FcsNib
);

   logic [31:0] crc;

   always_ff @(posedge MTxClk or negedge Reset_n) begin
      if (!Reset_n)        crc <= CRC_INIT;
      else if (Initialize) crc <= CRC_INIT;
      else if (Enable)     crc <= crcNibble(crc, Data);
      else if (Shift)      crc <= {crc[27:0], 4'h0};
   end

   // Complemented and bit-reversed so MTxD[0] carries the next FCS bit on the wire.
   assign FcsNib = ~{crc[28], crc[29], crc[30], crc[31]};

endmodule

// File: rtl/eth_txframer.sv
// MII transmit framer: preamble/SFD, data, optional pad, FCS, then a mandatory inter-packet gap.
// Build option ETH_TX_PAD_EN enables padding of short frames up to MIN_FRAME bytes.
module eth_txframer
   import eth_tx_pkg::*;
#(
   parameter int Tp        = 1,
   parameter int MIN_FRAME = 60,
   parameter int MAX_FRAME = 1518,
   parameter int IPG_NIB   = 24
) (
   input  logic       MTxClk,
   input  logic       Reset_n,
   input  logic       TxStartFrm,
   input  logic [7:0] TxData,
   input  logic       TxEndFrm,
   input  logic       CarrierSense,
   input  logic       Collision,
   output logic       TxUsedData,
   output logic       TxDone,
   output logic       TxAbort,
   output logic [3:0] MTxD,
   output logic       MTxEn,
   output logic       StateIdle,
   output logic       StatePreamble,
   output logic       StatePAD,
   output logic       StateFCS,
   output logic       StateJam,
   output logic       StateIPG,
   output logic [1:0] StateData
);

   if (Tp < 0 || MIN_FRAME < 1 || MAX_FRAME < MIN_FRAME + 5 || IPG_NIB < 2) begin : gParamCheck
      $error("eth_txframer: inconsistent frame/gap parameters");
   end

   txState_t    state;
   logic [15:0] nibCnt;
   logic [15:0] byteCnt;
   logic [3:0]  fcsNib;
   logic        crcInit;
   logic        crcEnable;
   logic        crcShift;
   logic [3:0]  crcData;

   // Handshake: TxStartFrm/TxData are valid from the request; a byte is taken at the end of
   // every cycle with TxUsedData high, after which the source must present the next byte.
   assign TxUsedData    = state[IDX_DATA1];
   assign StateIdle     = state[IDX_IDLE];
   assign StatePreamble = state[IDX_PREAMBLE];
   assign StateFCS      = state[IDX_FCS];
   assign StateJam      = state[IDX_JAM];
   assign StateIPG      = state[IDX_IPG];
   assign StateData     = {state[IDX_DATA1], state[IDX_DATA0]};
`ifdef ETH_TX_PAD_EN
   assign StatePAD      = state[IDX_PAD];
`else
   assign StatePAD      = 1'b0;
`endif

   assign crcInit   = state[IDX_PREAMBLE];
   assign crcEnable = state[IDX_DATA0] | state[IDX_DATA1] | StatePAD;
   assign crcShift  = state[IDX_FCS];
   assign crcData   = state[IDX_DATA0] ? TxData[3:0] :
                      state[IDX_DATA1] ? TxData[7:4] : 4'h0;

   eth_txcrc uCrc (
      .MTxClk     (MTxClk),
      .Reset_n    (Reset_n),
      .Initialize (crcInit),
      .Enable     (crcEnable),
      .Shift      (crcShift),
      .Data       (crcData),
      .FcsNib     (fcsNib)
   );

   always_ff @(posedge MTxClk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= ST_IPG;
         nibCnt  <= '0;
         byteCnt <= '0;
         MTxD    <= 4'h0;
         MTxEn   <= 1'b0;
         TxDone  <= 1'b0;
         TxAbort <= 1'b0;
      end else begin
         TxDone  <= 1'b0;
         TxAbort <= 1'b0;
         MTxD    <= 4'h0;
         MTxEn   <= 1'b0;
         nibCnt  <= nibCnt + 16'd1;
         case (state)
            ST_IDLE: begin
               nibCnt <= '0;
               if (TxStartFrm && !CarrierSense) begin
                  state   <= ST_PREAMBLE;
                  byteCnt <= '0;
               end
            end
            ST_PREAMBLE: begin
               MTxEn <= 1'b1;
               MTxD  <= (nibCnt == 16'(PREAMBLE_LEN - 1)) ? SFD_NIB : PREAMBLE_NIB;
               if (Collision) begin
                  state <= ST_JAM; nibCnt <= '0; byteCnt <= '0;
               end else if (nibCnt == 16'(PREAMBLE_LEN - 1)) begin
                  state <= ST_DATA0;
               end
            end
            ST_DATA0: begin
               MTxEn <= 1'b1;
               MTxD  <= TxData[3:0];
               if (Collision) begin
                  state <= ST_JAM; nibCnt <= '0; byteCnt <= '0;
               end else begin
                  state <= ST_DATA1;
               end
            end
            ST_DATA1: begin
               MTxEn   <= 1'b1;
               MTxD    <= TxData[7:4];
               byteCnt <= byteCnt + 16'd1;
               // Collision wins over end-of-frame in the same cycle.
               if (Collision) begin
                  state <= ST_JAM; nibCnt <= '0; byteCnt <= '0;
               end else if (TxEndFrm) begin
                  nibCnt <= '0;
`ifdef ETH_TX_PAD_EN
                  if (byteCnt + 16'd1 < 16'(MIN_FRAME)) state <= ST_PAD;
                  else                                  state <= ST_FCS;
`else
                  state <= ST_FCS;
`endif
               end else if (byteCnt + 16'd1 == 16'(MAX_FRAME - 4)) begin
                  state   <= ST_IPG;
                  nibCnt  <= '0;
                  byteCnt <= '0;
                  TxAbort <= 1'b1;
               end else begin
                  state <= ST_DATA0;
               end
            end
`ifdef ETH_TX_PAD_EN
            ST_PAD: begin
               MTxEn <= 1'b1;
               MTxD  <= 4'h0;
               if (nibCnt[0]) byteCnt <= byteCnt + 16'd1;
               if (Collision) begin
                  state <= ST_JAM; nibCnt <= '0; byteCnt <= '0;
               end else if (nibCnt[0] && (byteCnt + 16'd1 == 16'(MIN_FRAME))) begin
                  state  <= ST_FCS;
                  nibCnt <= '0;
               end
            end
`endif
            ST_FCS: begin
               MTxEn <= 1'b1;
               MTxD  <= fcsNib;
               if (Collision) begin
                  state <= ST_JAM; nibCnt <= '0; byteCnt <= '0;
               end else if (nibCnt == 16'(FCS_NIB - 1)) begin
                  state   <= ST_IPG;
                  nibCnt  <= '0;
                  byteCnt <= '0;
                  TxDone  <= 1'b1;
               end
            end
            ST_JAM: begin
               MTxEn <= 1'b1;
               MTxD  <= JAM_NIB;
               if (nibCnt == 16'(JAM_NIB_CNT - 1)) begin
                  state   <= ST_IPG;
                  nibCnt  <= '0;
                  byteCnt <= '0;
                  TxAbort <= 1'b1;
               end
            end
            ST_IPG: begin
               if (nibCnt == 16'(IPG_NIB - 1)) state <= ST_IDLE;
            end
            default: begin
               state  <= ST_IPG;
               nibCnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_txframer.sv
// Scoreboard bench for eth_txframer: expected nibbles, frame lengths and end events are queued
// by the frame driver and consumed by a negedge monitor whenever MTxEn or a pulse is seen.
module tb_eth_txframer;

   localparam int MIN_FRAME = 60;
   localparam int IPG_NIB   = 24;
   localparam logic [1:0] EV_DONE  = 2'b01;
   localparam logic [1:0] EV_ABORT = 2'b10;

   logic       MTxClk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       TxStartFrm = 1'b0;
   logic [7:0] TxData = 8'h00;
   logic       TxEndFrm = 1'b0;
   logic       CarrierSense = 1'b0;
   logic       Collision = 1'b0;
   logic       TxUsedData, TxDone, TxAbort, MTxEn;
   logic [3:0] MTxD;
   logic       StateIdle, StatePreamble, StatePAD, StateFCS, StateJam, StateIPG;
   logic [1:0] StateData;

   eth_txframer #(.Tp(1), .MIN_FRAME(MIN_FRAME), .MAX_FRAME(1518), .IPG_NIB(IPG_NIB)) dut (
      .MTxClk        (MTxClk),
      .Reset_n       (Reset_n),
      .TxStartFrm    (TxStartFrm),
      .TxData        (TxData),
      .TxEndFrm      (TxEndFrm),
      .CarrierSense  (CarrierSense),
      .Collision     (Collision),
      .TxUsedData    (TxUsedData),
      .TxDone        (TxDone),
      .TxAbort       (TxAbort),
      .MTxD          (MTxD),
      .MTxEn         (MTxEn),
      .StateIdle     (StateIdle),
      .StatePreamble (StatePreamble),
      .StatePAD      (StatePAD),
      .StateFCS      (StateFCS),
      .StateJam      (StateJam),
      .StateIPG      (StateIPG),
      .StateData     (StateData)
   );

   // clock / reset
   always #5 MTxClk = ~MTxClk;

   int         nChecks = 0;
   int         nFails  = 0;
   logic [3:0] exp_q[$];
   logic [1:0] ev_q[$];
   int         len_q[$];
   logic [7:0] frameBytes [0:1599];
   bit         monOn = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_crc(input int n, input int padBytes);
      logic [31:0] c;
      logic [7:0]  b;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n + padBytes; i++) begin
         b = (i < n) ? frameBytes[i] : 8'h00;
         c = c ^ {24'h0, b};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   // monitor / scoreboard
   int   runLen = 0;
   logic prevEn = 1'b0;
   always @(negedge MTxClk) begin
      if (!monOn) begin
         runLen = 0;
         prevEn = 1'b0;
      end else begin
         if (MTxEn) begin
            runLen++;
            if (exp_q.size() == 0) check("unexpected_nibble", {28'h0, MTxD}, 32'hFFFF_FFFF);
            else check("mtxd", {28'h0, MTxD}, {28'h0, exp_q.pop_front()});
         end else if (prevEn) begin
            if (len_q.size() == 0) check("unexpected_frame_len", runLen, 0);
            else check("mtxen_run_len", runLen, len_q.pop_front());
            runLen = 0;
         end
         if (TxDone || TxAbort) begin
            if (ev_q.size() == 0) check("unexpected_event", {30'h0, TxAbort, TxDone}, 0);
            else check("end_event", {30'h0, TxAbort, TxDone}, {30'h0, ev_q.pop_front()});
         end
         prevEn = MTxEn;
      end
   end

   task automatic fill_bytes(input int n, input int seed);
      for (int i = 0; i < n; i++) frameBytes[i] = 8'((i * 37 + seed * 11 + 5) & 8'hFF);
   endtask

   // driver: queue expectations, issue the request, feed bytes on TxUsedData
   task automatic run_frame(input int n, input bit useEnd, input int collideAt, input bit holdCs,
                            input bit useHandFcs, input logic [31:0] handFcs);
      int nib, cyc, idx, padBytes, idleCnt;
      logic [31:0] fcs;
      cyc = 0;
      while (!StateIdle && cyc < 200) begin @(posedge MTxClk); #1; cyc++; end
      check("idle_before_frame", StateIdle, 1);

      for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
      exp_q.push_back(4'hD);
      nib = 16;
      if (collideAt >= 0) begin
         for (int i = 0; i < collideAt; i++) begin
            exp_q.push_back(frameBytes[i][3:0]); exp_q.push_back(frameBytes[i][7:4]); nib += 2;
         end
         exp_q.push_back(frameBytes[collideAt][3:0]); nib++;
         for (int i = 0; i < 8; i++) exp_q.push_back(4'h9);
         nib += 8;
         ev_q.push_back(EV_ABORT);
      end else begin
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(frameBytes[i][3:0]); exp_q.push_back(frameBytes[i][7:4]); nib += 2;
         end
         if (!useEnd) begin
            ev_q.push_back(EV_ABORT);
         end else begin
            padBytes = 0;
`ifdef ETH_TX_PAD_EN
            if (n < MIN_FRAME) padBytes = MIN_FRAME - n;
`endif
            for (int i = 0; i < 2 * padBytes; i++) exp_q.push_back(4'h0);
            nib += 2 * padBytes;
            fcs = useHandFcs ? handFcs : ref_crc(n, padBytes);
            for (int k = 0; k < 8; k++) exp_q.push_back(fcs[4*k +: 4]);
            nib += 8;
            ev_q.push_back(EV_DONE);
         end
      end
      len_q.push_back(nib);

      TxStartFrm = 1'b1;
      TxData     = frameBytes[0];
      TxEndFrm   = useEnd && (n == 1);
      if (holdCs) begin
         CarrierSense = 1'b1;
         idleCnt = 0;
         for (int i = 0; i < 50; i++) begin
            @(posedge MTxClk); #1;
            if (StateIdle) idleCnt++;
         end
         check("defer_idle_cycles", idleCnt, 50);
         CarrierSense = 1'b0;
      end
      @(posedge MTxClk); #1;
      check("preamble_start", StatePreamble, 1);
      check("mtxen_low_at_start", MTxEn, 0);
      @(posedge MTxClk); #1;
      check("mtxen_rise", MTxEn, 1);

      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 4 * n + 100) begin
         @(negedge MTxClk); cyc++;
         if (TxUsedData) begin
            @(posedge MTxClk); #1;
            idx++;
            TxStartFrm = 1'b0;
            if (idx < n) begin
               TxData   = frameBytes[idx];
               TxEndFrm = useEnd && (idx == n - 1);
            end else begin
               TxEndFrm = 1'b0;
            end
            if (idx == collideAt) begin
               Collision = 1'b1;
               @(posedge MTxClk); #1;
               Collision = 1'b0;
               break;
            end
         end
      end
      check("bytes_consumed", idx, (collideAt >= 0) ? collideAt : n);
      TxStartFrm = 1'b0;
      TxEndFrm   = 1'b0;

      cyc = 0;
      while (!(TxDone || TxAbort) && cyc < 300) begin @(posedge MTxClk); #1; cyc++; end
      check("end_pulse_seen", TxDone | TxAbort, 1);
      @(posedge MTxClk); #1;
      check("end_pulse_one_cycle", TxDone | TxAbort, 0);
      check("ipg_mtxen_low", MTxEn, 0);
      cyc = 1;
      while (!StateIdle && cyc < 100) begin @(posedge MTxClk); #1; cyc++; end
      check("ipg_length", cyc, IPG_NIB);
   endtask

   initial begin
      int cnt, pulses;
      // reset state
      repeat (3) @(posedge MTxClk);
      #2;
      check("rst_mtxen", MTxEn, 0);
      check("rst_mtxd", MTxD, 0);
      check("rst_txdone", TxDone, 0);
      check("rst_txabort", TxAbort, 0);
      check("rst_txused", TxUsedData, 0);
      check("rst_state_ipg", StateIPG, 1);
      check("rst_state_idle", StateIdle, 0);
      Reset_n = 1'b1;
      monOn   = 1'b1;
      cnt = 0;
      while (!StateIdle && cnt < 100) begin @(posedge MTxClk); #1; cnt++; end
      check("post_reset_ipg", cnt, IPG_NIB);

      // "123456789": FCS 0xCBF43926 without padding
      for (int i = 0; i < 9; i++) frameBytes[i] = 8'h31 + 8'(i);
`ifdef ETH_TX_PAD_EN
      run_frame(9, 1'b1, -1, 1'b0, 1'b0, 32'h0);
`else
      run_frame(9, 1'b1, -1, 1'b0, 1'b1, 32'hCBF43926);
`endif
      fill_bytes(10, 1);
      run_frame(10, 1'b1, -1, 1'b0, 1'b0, 32'h0);
      fill_bytes(59, 2);
      run_frame(59, 1'b1, -1, 1'b0, 1'b0, 32'h0);
      fill_bytes(60, 3);
      run_frame(60, 1'b1, -1, 1'b0, 1'b0, 32'h0);
      fill_bytes(8, 4);
      run_frame(8, 1'b1, 3, 1'b0, 1'b0, 32'h0);
      check("no_fcs_state_after_jam", StateFCS, 0);
      fill_bytes(5, 5);
      run_frame(5, 1'b1, -1, 1'b1, 1'b0, 32'h0);
      fill_bytes(1514, 6);
      run_frame(1514, 1'b0, -1, 1'b0, 1'b0, 32'h0);

      // reset mid-frame
      monOn = 1'b0;
      TxStartFrm = 1'b1;
      TxData     = 8'hA5;
      repeat (30) @(posedge MTxClk);
      #1;
      check("midframe_mtxen_before_rst", MTxEn, 1);
      TxStartFrm = 1'b0;
      #2 Reset_n = 1'b0;
      #1;
      check("midframe_rst_mtxen", MTxEn, 0);
      check("midframe_rst_done", TxDone, 0);
      check("midframe_rst_abort", TxAbort, 0);
      check("midframe_rst_ipg", StateIPG, 1);
      check("midframe_rst_data", StateData, 0);
      @(posedge MTxClk); #2;
      Reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge MTxClk); #1;
         if (TxDone || TxAbort || MTxEn) pulses++;
      end
      check("midframe_no_events", pulses, 0);

      check("exp_q_empty", exp_q.size(), 0);
      check("ev_q_empty", ev_q.size(), 0);
      check("len_q_empty", len_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
